// File: rtl/cs_out_buf.sv
// cs_out_buf: output stage of the CS filter.
// Discards the first WARMUP samples after reset (window fill), then pushes one
// Y sample per clock into a show-ahead FIFO. The FIFO drains over a valid/ready
// handshake. When the FIFO is full and nothing pops, the newest sample is dropped.
// Drops are flagged (sticky ovf) and counted (saturating drop_cnt).
module cs_out_buf #(
  parameter int DW     = 10,
  parameter int DEPTH  = 8,
  parameter int WARMUP = 8,
  parameter int CW     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DW-1:0]            y_in,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     warm,
  output logic                     ovf,
  output logic [CW-1:0]            drop_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int WCW = $clog2(WARMUP + 1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_r;
  logic [WCW-1:0]  wcnt_r;
  logic            warm_r;

  logic [DW-1:0]   mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic            out_valid_r;
  logic            ovf_r;
  logic [CW-1:0]   drop_cnt_r;

  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            push_ok_s;
  logic            drop_s;
  logic [LW-1:0]   level_next_s;

  // Warm-up FSM: count discarded fill samples, then stay in RUN until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_FILL;
      wcnt_r  <= WCW'(0);
      warm_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          wcnt_r <= wcnt_r + WCW'(1);
          if (wcnt_r == WCW'(WARMUP - 1)) begin
            state_r <= ST_RUN;
            warm_r  <= 1'b1;
          end else begin
            state_r <= ST_FILL;
            warm_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          warm_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_FILL;
          wcnt_r  <= WCW'(0);
          warm_r  <= 1'b0;
        end
      endcase
    end
  end

  // Push/pop arbitration: a full FIFO accepts a push only when it pops on the same edge.
  always_comb begin
    push_s       = (state_r == ST_RUN);
    pop_s        = out_valid_r && out_ready;
    full_s       = (level_r == LW'(DEPTH));
    push_ok_s    = 1'b0;
    drop_s       = 1'b0;
    level_next_s = level_r;
    if (push_s) begin
      if (!full_s || pop_s) begin
        push_ok_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_ok_s = 1'b0;
      drop_s    = 1'b0;
    end
    case ({push_ok_s, pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Storage write; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && push_ok_s) begin
      mem_r[wr_ptr_r] <= y_in;
    end
  end

  // FIFO bookkeeping and overflow reporting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r    <= AW'(0);
      rd_ptr_r    <= AW'(0);
      level_r     <= LW'(0);
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      drop_cnt_r  <= CW'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r     <= level_next_s;
      out_valid_r <= (level_next_s != LW'(0));
      if (drop_s) begin
        ovf_r <= 1'b1;
        if (drop_cnt_r != {CW{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + CW'(1);
        end
      end
    end
  end

  assign out_data  = mem_r[rd_ptr_r];
  assign out_valid = out_valid_r;
  assign level     = level_r;
  assign warm      = warm_r;
  assign ovf       = ovf_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_cs_out_buf.sv
// Bench for cs_out_buf: scenario tasks checked against a queue-based model.
// A second instance with a 4-bit drop counter exercises counter saturation.
module tb_cs_out_buf;

  localparam int DW     = 10;
  localparam int DEPTH  = 8;
  localparam int WARMUP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] y_in;
  logic          out_ready;

  logic [DW-1:0] out_data,  out_data4;
  logic          out_valid, out_valid4;
  logic [3:0]    level,     level4;
  logic          warm,      warm4;
  logic          ovf,       ovf4;
  logic [15:0]   drop_cnt;
  logic [3:0]    drop_cnt4;

  int checks = 0;
  int errors = 0;

  // reference model state
  int            m_since;
  int            m_drops;
  logic [DW-1:0] m_q[$];

  always #5 clk = ~clk;

  cs_out_buf #(.DW(DW), .DEPTH(DEPTH), .WARMUP(WARMUP), .CW(16)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .warm(warm), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  cs_out_buf #(.DW(DW), .DEPTH(DEPTH), .WARMUP(WARMUP), .CW(4)) dut4 (
    .clk(clk), .reset(reset), .y_in(y_in), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready), .level(level4), .warm(warm4), .ovf(ovf4), .drop_cnt(drop_cnt4)
  );

  // Model of one rising edge, using the inputs currently applied.
  task automatic model_edge();
    bit pop_b;
    bit push_b;
    if (!reset) begin
      m_q.delete();
      m_since = 0;
      m_drops = 0;
    end else begin
      pop_b  = (m_q.size() > 0) && out_ready;
      push_b = (m_since >= WARMUP);
      if (m_since < WARMUP) m_since++;
      if (pop_b) void'(m_q.pop_front());
      if (push_b) begin
        if (m_q.size() < DEPTH) m_q.push_back(y_in);
        else m_drops++;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b0; y_in = 10'd0;
    step(); step();
    checks++; if (level !== 4'd0)     begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (warm !== 1'b0)      begin errors++; $display("FAIL reset_warm got %0b exp 0", warm); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %0b exp 0", ovf); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
    checks++; if (drop_cnt4 !== 4'd0) begin errors++; $display("FAIL reset_drop4 got %0d exp 0", drop_cnt4); end
  endtask

  task automatic test_warmup();
    reset = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= WARMUP + 6; k++) begin
      y_in = DW'(k - 1);
      step();
      checks++; if (warm !== (k >= WARMUP)) begin errors++; $display("FAIL warmup_warm k=%0d got %0b exp %0b", k, warm, (k >= WARMUP)); end
      checks++; if (out_valid !== (k >= WARMUP + 1)) begin errors++; $display("FAIL warmup_valid k=%0d got %0b exp %0b", k, out_valid, (k >= WARMUP + 1)); end
      checks++; if (level !== 4'(m_q.size())) begin errors++; $display("FAIL warmup_level k=%0d got %0d exp %0d", k, level, m_q.size()); end
      if (k >= WARMUP + 1) begin
        checks++; if (out_data !== DW'(k - 1)) begin errors++; $display("FAIL warmup_data k=%0d got %0h exp %0h", k, out_data, k - 1); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] first;
    reset = 1'b0; out_ready = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 0; k < WARMUP; k++) begin
      y_in = DW'($urandom);
      step();
    end
    first = 10'd0;
    for (int i = 1; i <= DEPTH; i++) begin
      y_in = DW'($urandom);
      if (i == 1) first = y_in;
      step();
      checks++; if (level !== 4'(i)) begin errors++; $display("FAIL bp_level i=%0d got %0d exp %0d", i, level, i); end
      checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL bp_ovf i=%0d got %0b exp 0", i, ovf); end
    end
    y_in = DW'($urandom);
    step();
    checks++; if (level !== 4'd8)     begin errors++; $display("FAIL bp_full_level got %0d exp 8", level); end
    checks++; if (ovf !== 1'b1)       begin errors++; $display("FAIL bp_full_ovf got %0b exp 1", ovf); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL bp_drop1 got %0d exp 1", drop_cnt); end
    for (int i = 0; i < 5; i++) begin
      y_in = DW'($urandom);
      step();
    end
    checks++; if (drop_cnt !== 16'd6)        begin errors++; $display("FAIL bp_drop6 got %0d exp 6", drop_cnt); end
    checks++; if (drop_cnt !== 16'(m_drops)) begin errors++; $display("FAIL bp_drop_model got %0d exp %0d", drop_cnt, m_drops); end
    checks++; if (out_data !== first)        begin errors++; $display("FAIL bp_head got %0h exp %0h", out_data, first); end
  endtask

  task automatic test_full_drain();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      y_in = DW'($urandom);
      checks++; if (out_data !== m_q[0]) begin errors++; $display("FAIL drain_data i=%0d got %0h exp %0h", i, out_data, m_q[0]); end
      step();
      checks++; if (level !== 4'd8)     begin errors++; $display("FAIL drain_level i=%0d got %0d exp 8", i, level); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid i=%0d got %0b exp 1", i, out_valid); end
      checks++; if (drop_cnt !== 16'd6) begin errors++; $display("FAIL drain_drop i=%0d got %0d exp 6", i, drop_cnt); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      y_in = DW'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      checks++; if (out_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid i=%0d got %0b exp %0b", i, out_valid, (m_q.size() > 0)); end
      if (out_valid && out_ready && m_q.size() > 0) begin
        checks++; if (out_data !== m_q[0]) begin errors++; $display("FAIL rnd_data i=%0d got %0h exp %0h", i, out_data, m_q[0]); end
      end
      step();
      checks++; if (level !== 4'(m_q.size()))  begin errors++; $display("FAIL rnd_level i=%0d got %0d exp %0d", i, level, m_q.size()); end
      checks++; if (drop_cnt !== 16'(m_drops)) begin errors++; $display("FAIL rnd_drop i=%0d got %0d exp %0d", i, drop_cnt, m_drops); end
      checks++; if (ovf !== (m_drops > 0))     begin errors++; $display("FAIL rnd_ovf i=%0d got %0b exp %0b", i, ovf, (m_drops > 0)); end
    end
  endtask

  task automatic test_mid_reset();
    // one-clock reset straight from the busy, overflowed random state
    reset = 1'b0;
    step();
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL mid1_level got %0d exp 0", level); end
    checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL mid1_ovf got %0b exp 0", ovf); end
    checks++; if (warm !== 1'b0)  begin errors++; $display("FAIL mid1_warm got %0b exp 0", warm); end
    reset = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < WARMUP + 5; k++) begin
      y_in = DW'($urandom);
      step();
    end
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL mid_pre_level got %0d exp 5", level); end
    reset = 1'b0;
    step();
    checks++; if (level !== 4'd0)     begin errors++; $display("FAIL mid2_level got %0d exp 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid2_valid got %0b exp 0", out_valid); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL mid2_ovf got %0b exp 0", ovf); end
    checks++; if (warm !== 1'b0)      begin errors++; $display("FAIL mid2_warm got %0b exp 0", warm); end
    reset = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= WARMUP + 1; k++) begin
      y_in = DW'($urandom);
      step();
      checks++; if (warm !== (k >= WARMUP)) begin errors++; $display("FAIL mid_warm k=%0d got %0b exp %0b", k, warm, (k >= WARMUP)); end
      checks++; if (out_valid !== (k == WARMUP + 1)) begin errors++; $display("FAIL mid_valid k=%0d got %0b exp %0b", k, out_valid, (k == WARMUP + 1)); end
      if (k == WARMUP + 1) begin
        checks++; if (out_data !== y_in) begin errors++; $display("FAIL mid_data got %0h exp %0h", out_data, y_in); end
      end
    end
  endtask

  task automatic test_drop_sat();
    int exp4;
    reset = 1'b0; out_ready = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 0; k < WARMUP; k++) begin
      y_in = DW'($urandom);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      y_in = DW'($urandom);
      step();
      exp4 = (m_drops > 15) ? 15 : m_drops;
      checks++; if (drop_cnt4 !== 4'(exp4))     begin errors++; $display("FAIL sat_drop4 i=%0d got %0d exp %0d", i, drop_cnt4, exp4); end
      checks++; if (drop_cnt !== 16'(m_drops))  begin errors++; $display("FAIL sat_drop16 i=%0d got %0d exp %0d", i, drop_cnt, m_drops); end
    end
    checks++; if (drop_cnt4 !== 4'hF)  begin errors++; $display("FAIL sat_final4 got %0h exp f", drop_cnt4); end
    checks++; if (drop_cnt !== 16'd32) begin errors++; $display("FAIL sat_final16 got %0d exp 32", drop_cnt); end
    checks++; if (ovf4 !== 1'b1)       begin errors++; $display("FAIL sat_ovf4 got %0b exp 1", ovf4); end
  endtask

  initial begin
    m_since = 0;
    m_drops = 0;
    test_reset();
    test_warmup();
    test_backpressure();
    test_full_drain();
    test_random();
    test_mid_reset();
    test_drop_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
